// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Instruction-fetch stage. Holds the PC, reads 16-bit words from
//             instruction memory, assembles one- or two-word instructions
//             (opcode word plus optional immediate word) and hands registered
//             opCode/Rs/Rd/immediate fields to decode. Supports downstream
//             stall and branch redirect from execute.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [4:0]        id_opCode,
    output logic [2:0]        id_Rs,
    output logic [2:0]        id_Rd,
    output logic [15:0]       id_imm,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_valid
);

    // FETCH_OP: next word is an opcode word.
    // FETCH_IMM: opcode word is parked in r_hold_word, next word is its immediate.
    typedef enum logic [0:0] {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_hold_word;
    logic [ADDR_W-1:0] r_hold_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // Low five bits of an opcode word carry no information for decode.
    logic              w_unused;

    // Sequential PC advance wraps naturally at 2^ADDR_W.
    assign w_pc_next = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign imem_addr = r_pc;
    assign w_unused  = ^{imem_data[4:0], r_hold_word[4:0]};

    // Fetch state machine: PC, hold registers and registered IF/ID fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_state     <= FETCH_OP;
            r_hold_word <= '0;
            r_hold_pc   <= '0;
            id_opCode   <= '0;
            id_Rs       <= '0;
            id_Rd       <= '0;
            id_imm      <= '0;
            id_pc       <= '0;
            id_valid    <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over stall; any half-assembled instruction is dropped
            // and decode sees a single bubble.
            r_pc      <= branch_target;
            r_state   <= FETCH_OP;
            id_opCode <= '0;
            id_Rs     <= '0;
            id_Rd     <= '0;
            id_imm    <= '0;
            id_pc     <= '0;
            id_valid  <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                FETCH_OP: begin
                    r_pc <= w_pc_next;
                    if (imem_data[15]) begin
                        // Two-word instruction: park the opcode word, emit a bubble.
                        r_hold_word <= imem_data;
                        r_hold_pc   <= r_pc;
                        r_state     <= FETCH_IMM;
                        id_opCode   <= '0;
                        id_Rs       <= '0;
                        id_Rd       <= '0;
                        id_imm      <= '0;
                        id_pc       <= '0;
                        id_valid    <= 1'b0;
                    end else begin
                        id_opCode <= imem_data[15:11];
                        id_Rs     <= imem_data[10:8];
                        id_Rd     <= imem_data[7:5];
                        id_imm    <= '0;
                        id_pc     <= r_pc;
                        id_valid  <= 1'b1;
                    end
                end
                FETCH_IMM: begin
                    // Current word is the immediate of the parked opcode word.
                    r_pc      <= w_pc_next;
                    r_state   <= FETCH_OP;
                    id_opCode <= r_hold_word[15:11];
                    id_Rs     <= r_hold_word[10:8];
                    id_Rd     <= r_hold_word[7:5];
                    id_imm    <= imem_data;
                    id_pc     <= r_hold_pc;
                    id_valid  <= 1'b1;
                end
                default: begin
                    r_state <= FETCH_OP;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Scoreboard bench for instruction_fetch. An instruction-level
//             model pushes each expected instruction when its last word is
//             fetched; a monitor pops and compares whenever decode sees a
//             new valid instruction, and checks bubbles and stall freezing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int C_AW = 16;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            branch_taken;
    logic [C_AW-1:0] branch_target;
    logic [C_AW-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [4:0]      id_opCode;
    logic [2:0]      id_Rs;
    logic [2:0]      id_Rd;
    logic [15:0]     id_imm;
    logic [C_AW-1:0] id_pc;
    logic            id_valid;

    logic [15:0] mem [0:65535];
    assign imem_data = mem[imem_addr];

    instruction_fetch #(
        .ADDR_W   (C_AW),
        .RESET_PC (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .id_opCode     (id_opCode),
        .id_Rs         (id_Rs),
        .id_Rd         (id_Rd),
        .id_imm        (id_imm),
        .id_pc         (id_pc),
        .id_valid      (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic [15:0] pc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Instruction-level model: start address of the instruction being
    // assembled and how many of its words have already been fetched.
    logic [15:0] cur;
    int          got;
    logic [15:0] exp_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model for the coming edge,
    // then return 2 time units after that edge.
    task automatic step(input logic s, input logic b, input logic [15:0] t);
        logic [15:0] w;
        logic [15:0] nx;
        int          len;
        exp_t        e;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        if (b) begin
            cur = t;
            got = 0;
        end else if (!s) begin
            w   = mem[cur];
            len = w[15] ? 2 : 1;
            got = got + 1;
            if (got == len) begin
                nx    = cur + 16'd1;
                e.op  = w[15:11];
                e.rs  = w[10:8];
                e.rd  = w[7:5];
                e.imm = (len == 2) ? mem[nx] : 16'h0000;
                e.pc  = cur;
                q.push_back(e);
                cur = cur + 16'(len);
                got = 0;
            end
        end
        exp_addr = cur + 16'(got);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares DUT outputs 1 time unit after every rising edge.
    initial begin : monitor
        logic        l_rst, l_br, l_st;
        logic [4:0]  p_op;
        logic [2:0]  p_rs, p_rd;
        logic [15:0] p_imm, p_pc;
        logic        p_v;
        exp_t        e;
        p_op = '0; p_rs = '0; p_rd = '0; p_imm = '0; p_pc = '0; p_v = 1'b0;
        forever begin
            @(posedge clk);
            l_rst = rst;
            l_br  = branch_taken;
            l_st  = stall;
            #1;
            chk("imem_addr", 32'(imem_addr), 32'(exp_addr));
            if (l_rst || l_br || (!l_st && !id_valid)) begin
                chk("bubble_valid", 32'(id_valid), 32'd0);
                chk("bubble_fields", {8'd0, id_opCode, id_Rs, id_Rd, id_imm},
                    32'd0);
                chk("bubble_pc", 32'(id_pc), 32'd0);
            end else if (l_st) begin
                chk("stall_valid", 32'(id_valid), 32'(p_v));
                chk("stall_fields", {8'd0, id_opCode, id_Rs, id_Rd, id_imm},
                    {8'd0, p_op, p_rs, p_rd, p_imm});
                chk("stall_pc", 32'(id_pc), 32'(p_pc));
            end else if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got pc %0h expected no instruction at %0t",
                         id_pc, $time);
            end else begin
                e = q.pop_front();
                chk("opCode", 32'(id_opCode), 32'(e.op));
                chk("Rs",     32'(id_Rs),     32'(e.rs));
                chk("Rd",     32'(id_Rd),     32'(e.rd));
                chk("imm",    32'(id_imm),    32'(e.imm));
                chk("id_pc",  32'(id_pc),     32'(e.pc));
            end
            p_op = id_opCode; p_rs = id_Rs; p_rd = id_Rd;
            p_imm = id_imm; p_pc = id_pc; p_v = id_valid;
        end
    end

    // Watchdog so the run always terminates.
    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1, "timeout");
    end

    // Stimulus: directed program, then randomized stall/branch traffic.
    initial begin : stim
        logic        s, b;
        logic [15:0] t;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0000] = 16'h08A0;
        mem[16'h0001] = 16'h1040;
        mem[16'h0002] = 16'hC120;
        mem[16'h0003] = 16'hBEEF;
        mem[16'h0004] = 16'h2060;
        mem[16'h0005] = 16'h9A40;
        mem[16'h0006] = 16'h1234;
        mem[16'h0007] = 16'h18E0;
        mem[16'h0008] = 16'hF8E0;
        mem[16'h0009] = 16'h5555;
        mem[16'h0040] = 16'h28C0;
        mem[16'h0041] = 16'h3000;
        mem[16'hFFFF] = 16'hA2A0;

        // Reset held two cycles with a competing branch request.
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h1234;
        cur           = 16'h0000;
        got           = 0;
        exp_addr      = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_addr",  32'(imem_addr), 32'h0);
        chk("reset_valid", 32'(id_valid),  32'h0);
        rst          = 1'b0;
        branch_taken = 1'b0;

        step(1'b0, 1'b0, 16'h0);
        chk("dir_op0",  32'(id_opCode), 32'd1);
        chk("dir_rd0",  32'(id_Rd),     32'd5);
        chk("dir_pc0",  32'(id_pc),     32'd0);
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("dir_op1",  32'(id_opCode), 32'd2);
        step(1'b0, 1'b0, 16'h0);
        chk("dir_bubble2", 32'(id_valid), 32'd0);
        step(1'b0, 1'b0, 16'h0);
        chk("dir_op2",  32'(id_opCode), 32'd24);
        chk("dir_imm2", 32'(id_imm),    32'hBEEF);
        chk("dir_addr2", 32'(imem_addr), 32'd4);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        repeat (3) step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("dir_imm5", 32'(id_imm), 32'h1234);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        // Branch together with stall while the F8E0 opcode word is parked.
        step(1'b1, 1'b1, 16'h0040);
        chk("br_addr",  32'(imem_addr), 32'h40);
        chk("br_valid", 32'(id_valid),  32'd0);
        step(1'b0, 1'b0, 16'h0);
        chk("br_op",    32'(id_opCode), 32'd5);
        // Two-word instruction straddling the top of the address space.
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("wrap_pc",   32'(id_pc),     32'hFFFF);
        chk("wrap_imm",  32'(id_imm),    32'h08A0);
        chk("wrap_addr", 32'(imem_addr), 32'h1);

        // Randomized traffic with occasional redirects near the wrap point.
        for (int n = 0; n < 600; n++) begin
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 3))
                                            : 16'($urandom);
            step(s, b, t);
        end
        step(1'b0, 1'b0, 16'h0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
